// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B, LSB first) with a Start/Done handshake.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Start_In,
  input  logic [WIDTH-1:0] Data_A_In,
  input  logic [WIDTH-1:0] Data_B_In,
  output logic             Busy_Out,
  output logic             Done_Out,
  output logic [WIDTH-1:0] Difference_Out,
  output logic             Borrow_Out
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             Overflow_Out
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic [WIDTH-1:0] r_resSr;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrowOut;
  logic             r_borrow;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_resNext;
  logic             w_a;
  logic             w_b;
  logic             w_d1;
  logic             w_b1;
  logic             w_d;
  logic             w_b2;
  logic             w_bo;
  logic             w_last;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             r_aMsb;
  logic             r_bMsb;
  logic             r_ovf;
`endif

  // Two half-subtractors chained through the registered borrow form one full subtractor.
  always_comb begin
    w_a       = r_aSr[0];
    w_b       = r_bSr[0];
    w_d1      = w_a ^ w_b;
    w_b1      = ~w_a & w_b;
    w_d       = w_d1 ^ r_borrow;
    w_b2      = ~w_d1 & r_borrow;
    w_bo      = w_b1 | w_b2;
    w_last    = (r_count == LAST);
    w_resNext = r_resSr >> 1;
    w_resNext[WIDTH-1] = w_d;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (Start_In) w_nextState = RUN;
      RUN:     if (w_last) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_aSr       <= '0;
      r_bSr       <= '0;
      r_resSr     <= '0;
      r_diff      <= '0;
      r_borrowOut <= 1'b0;
      r_borrow    <= 1'b0;
      r_count     <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      r_aMsb      <= 1'b0;
      r_bMsb      <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (Start_In) begin
            r_aSr    <= Data_A_In;
            r_bSr    <= Data_B_In;
            r_borrow <= 1'b0;
            r_count  <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_aMsb   <= Data_A_In[WIDTH-1];
            r_bMsb   <= Data_B_In[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r_aSr    <= r_aSr >> 1;
          r_bSr    <= r_bSr >> 1;
          r_resSr  <= w_resNext;
          r_borrow <= w_bo;
          r_count  <= r_count + CW'(1);
          if (w_last) begin
            r_diff      <= w_resNext;
            r_borrowOut <= w_bo;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_ovf       <= (r_aMsb != r_bMsb) && (w_resNext[WIDTH-1] != r_aMsb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy_Out       = (r_state != IDLE);
  assign Done_Out       = (r_state == DONE);
  assign Difference_Out = r_diff;
  assign Borrow_Out     = r_borrowOut;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign Overflow_Out   = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dataA;
  logic [7:0] dataB;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       start1;
  logic       dataA1;
  logic       dataB1;
  logic       busy1;
  logic       done1;
  logic       diff1;
  logic       borrow1;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic       ovf;
  logic       ovf1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut (
    .Clk_In(clk), .Reset_In(reset), .Start_In(start),
    .Data_A_In(dataA), .Data_B_In(dataB),
    .Busy_Out(busy), .Done_Out(done),
    .Difference_Out(diff), .Borrow_Out(borrow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    , .Overflow_Out(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .Clk_In(clk), .Reset_In(reset), .Start_In(start1),
    .Data_A_In(dataA1), .Data_B_In(dataB1),
    .Busy_Out(busy1), .Done_Out(done1),
    .Difference_Out(diff1), .Borrow_Out(borrow1)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    , .Overflow_Out(ovf1)
`endif
  );

  // Launch one 8-bit operation; cyc counts negedges after E0 until Done (bounded).
  task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                       output int cyc, output int busyCycles);
    @(negedge clk);
    dataA = a; dataB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busyCycles = busy ? 1 : 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) busyCycles++;
    end
    @(negedge clk);
    if (busy) busyCycles++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({busy, done, diff, borrow} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b diff=%h borrow=%b want all 0", busy, done, diff, borrow);
    end
    vectors++;
    if ({busy1, done1, diff1, borrow1} !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs_w1 got %b want 0000", {busy1, done1, diff1, borrow1});
    end
  endtask

  task automatic test_basic();
    int cyc, bc;
    runOp(8'h3C, 8'h1A, cyc, bc);
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("[TB] FAIL basic_latency got %0d want 8", cyc);
    end
    vectors++;
    if (diff !== 8'h22 || borrow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_result got %h/%b want 22/0", diff, borrow);
    end
    vectors++;
    if (bc !== 9) begin
      miscompares++;
      $display("[TB] FAIL basic_busy_cycles got %0d want 9", bc);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_idle_after got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] aT[6]   = '{8'h05, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h10};
    logic [7:0] bT[6]   = '{8'h07, 8'h00, 8'hFF, 8'h01, 8'hFF, 8'h20};
    logic [7:0] dT[6]   = '{8'hFE, 8'h00, 8'h00, 8'h7F, 8'h80, 8'hF0};
    logic       brT[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ovT[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int cyc, bc;
    for (int i = 0; i < 6; i++) begin
      runOp(aT[i], bT[i], cyc, bc);
      vectors++;
      if (cyc !== 8 || diff !== dT[i] || borrow !== brT[i]) begin
        miscompares++;
        $display("[TB] FAIL pattern_%0d got cyc=%0d %h/%b want 8 %h/%b", i, cyc, diff, borrow, dT[i], brT[i]);
      end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      vectors++;
      if (ovf !== ovT[i]) begin
        miscompares++;
        $display("[TB] FAIL overflow_%0d got %b want %b", i, ovf, ovT[i]);
      end
`else
      if (ovT[i] === 1'bx) $display("[TB] unexpected table entry");
`endif
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit sawAccept = 0;
    bit sawDone2 = 0;
    @(negedge clk);
    dataA = 8'h10; dataB = 8'h01; start = 1'b1;
    @(negedge clk);
    dataA = 8'h99; dataB = 8'h11;
    for (cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      if (cyc == 8) begin
        vectors++;
        if (done !== 1'b1 || diff !== 8'h0F || borrow !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b_first got done=%b %h/%b want 1 0F/0", done, diff, borrow);
        end
      end
      if (cyc == 9) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b_gap_idle got busy=%b want 0", busy);
        end
      end
      if (cyc == 10) begin
        start = 1'b0;
        sawAccept = busy;
      end
      if (cyc == 14) begin
        vectors++;
        if (diff !== 8'h0F || done !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b_hold got diff=%h done=%b want 0F/0", diff, done);
        end
      end
      if (cyc == 18) sawDone2 = done;
    end
    vectors++;
    if (sawAccept !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept_e10 got busy=%b want 1", sawAccept);
    end
    vectors++;
    if (sawDone2 !== 1'b1 || diff !== 8'h88 || borrow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_second got done=%b %h/%b want 1 88/0", sawDone2, diff, borrow);
    end
  endtask

  task automatic test_reset_mid_run();
    int doneSeen = 0;
    int cyc, bc;
    @(negedge clk);
    dataA = 8'h80; dataB = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({busy, done, diff, borrow} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset got busy=%b done=%b diff=%h borrow=%b want all 0", busy, done, diff, borrow);
    end
    repeat (12) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    vectors++;
    if (doneSeen !== 0) begin
      miscompares++;
      $display("[TB] FAIL midrun_no_done got %0d pulses want 0", doneSeen);
    end
    runOp(8'h80, 8'h01, cyc, bc);
    vectors++;
    if (cyc !== 8 || diff !== 8'h7F || borrow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrun_fresh got cyc=%0d %h/%b want 8 7F/0", cyc, diff, borrow);
    end
  endtask

  task automatic test_width1();
    logic aT[3] = '{1'b0, 1'b1, 1'b1};
    logic bT[3] = '{1'b1, 1'b0, 1'b1};
    logic dT[3] = '{1'b1, 1'b1, 1'b0};
    logic rT[3] = '{1'b1, 1'b0, 1'b0};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dataA1 = aT[i]; dataB1 = bT[i]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      cyc = 0;
      while (!done1 && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      vectors++;
      if (cyc !== 1 || diff1 !== dT[i] || borrow1 !== rT[i]) begin
        miscompares++;
        $display("[TB] FAIL width1_%0d got cyc=%0d %b/%b want 1 %b/%b", i, cyc, diff1, borrow1, dT[i], rT[i]);
      end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      vectors++;
      if (ovf1 !== (aT[i] != bT[i] && dT[i] != aT[i])) begin
        miscompares++;
        $display("[TB] FAIL width1_ovf_%0d got %b", i, ovf1);
      end
`endif
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dataA = '0; dataB = '0;
    start1 = 1'b0; dataA1 = 1'b0; dataB1 = 1'b0;
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
